// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one-cycle-latency
// instruction memory reads steered by the branch predictor, and queues the
// returned words with their prediction metadata for decode.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] fetch_pc_o,
    input  logic [31:0] pred_pc_i,
    input  logic        pred_taken_i,
    input  logic        stall_bp_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Architectural fetch PC and the single outstanding memory request
    logic [31:0]      pc_q, pc_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    logic             inflight_taken_q, inflight_taken_d;
    logic [31:0]      inflight_target_q, inflight_target_d;

    // Circular fetch buffer bookkeeping
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    logic [31:0]      buf_instr_q  [BUF_DEPTH];
    logic [31:0]      buf_pc_q     [BUF_DEPTH];
    logic             buf_taken_q  [BUF_DEPTH];
    logic [31:0]      buf_target_q [BUF_DEPTH];

    logic             pop;
    logic             push;
    logic             issue;
    logic [CNT_W:0]   occupancy;
    logic [31:0]      pred_aligned;
    logic [31:0]      redirect_aligned;

    // Masking keeps the full input word in use while forcing word alignment
    assign pred_aligned     = pred_pc_i & ~32'h3;
    assign redirect_aligned = redirect_pc_i & ~32'h3;

    // A flush hides the head immediately so decode never consumes wrong-path work
    assign valid_o = ~flush_i & (count_q != '0);
    assign pop     = valid_o & ready_i;
    assign push    = inflight_q & ~flush_i;

    // Slots that will be occupied after this cycle's pop, counting the
    // response still on its way back; issue only if one slot remains free
    assign occupancy = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    assign issue     = rst_n & ~flush_i & ~stall_bp_i
                     & (occupancy < (CNT_W+1)'(BUF_DEPTH));

    assign imem_req_o  = issue;
    assign imem_addr_o = pc_q;
    assign fetch_pc_o  = pc_q;

    assign instr_o       = buf_instr_q[rd_ptr_q];
    assign pc_o          = buf_pc_q[rd_ptr_q];
    assign pred_taken_o  = buf_taken_q[rd_ptr_q];
    assign pred_target_o = buf_target_q[rd_ptr_q];

    // Next-state for PC, in-flight tracking and buffer pointers; flush wins
    always_comb begin
        pc_d              = pc_q;
        inflight_d        = 1'b0;
        inflight_pc_d     = inflight_pc_q;
        inflight_taken_d  = inflight_taken_q;
        inflight_target_d = inflight_target_q;
        count_d           = count_q;
        wr_ptr_d          = wr_ptr_q;
        rd_ptr_d          = rd_ptr_q;

        if (flush_i) begin
            pc_d     = redirect_aligned;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (issue) begin
                pc_d              = pred_aligned;
                inflight_d        = 1'b1;
                inflight_pc_d     = pc_q;
                inflight_taken_d  = pred_taken_i;
                inflight_target_d = pred_aligned;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q              <= RESET_PC;
            inflight_q        <= 1'b0;
            inflight_pc_q     <= '0;
            inflight_taken_q  <= 1'b0;
            inflight_target_q <= '0;
            count_q           <= '0;
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
        end else begin
            pc_q              <= pc_d;
            inflight_q        <= inflight_d;
            inflight_pc_q     <= inflight_pc_d;
            inflight_taken_q  <= inflight_taken_d;
            inflight_target_q <= inflight_target_d;
            count_q           <= count_d;
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
        end
    end

    // Buffer entries are cleared on reset so the head outputs read zero
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
        // Capture the returning instruction into the tail slot
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                buf_instr_q[gi]  <= '0;
                buf_pc_q[gi]     <= '0;
                buf_taken_q[gi]  <= 1'b0;
                buf_target_q[gi] <= '0;
            end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
                buf_instr_q[gi]  <= imem_rdata_i;
                buf_pc_q[gi]     <= inflight_pc_q;
                buf_taken_q[gi]  <= inflight_taken_q;
                buf_target_q[gi] <= inflight_target_q;
            end
        end
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage that owns the architectural PC and drives instruction memory.
- Each cycle it presents the fetch PC to the branch predictor and takes the predicted next PC back (PC+4 on a BTB miss, the stored target on a hit).
- It buffers returned instructions with their prediction metadata in a small FIFO and hands them to decode over a valid/ready handshake.
- Decode's resolution logic drives flush_i/redirect_pc_i to kill wrong-path work.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
BUF_DEPTH, 2, fetch buffer entries (power of two, >=2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
fetch_pc_o  output  32  current fetch PC, to predictor PC input (equals imem_addr_o)
pred_pc_i  input  32  predicted next PC from predictor, combinational on fetch_pc_o
pred_taken_i  input  1  predictor BTB hit for fetch_pc_o
stall_bp_i  input  1  predictor stall request; blocks issue
imem_req_o  output  1  instruction read request this cycle
imem_addr_o  output  32  read address, word aligned
imem_rdata_i  input  32  read data, valid exactly one cycle after request
flush_i  input  1  mispredict/redirect from decode
redirect_pc_i  input  32  correct target when flush_i=1
valid_o  output  1  buffer head valid to decode
ready_i  input  1  decode accepts head
instr_o  output  32  head instruction word
pc_o  output  32  head instruction PC
pred_taken_o  output  1  head was predicted taken
pred_target_o  output  32  head's predicted next PC

Behaviour:
- Reset (async, any time): pc_q=RESET_PC, buffer empty, in-flight flag cleared. Outputs: valid_o=0, imem_req_o=0, instr_o/pc_o/pred_target_o=0, pred_taken_o=0. Reset mid-operation drops all buffered and in-flight instructions.
- pop = valid_o & ready_i.
- issue = ~flush_i & ~stall_bp_i & (count + inflight_q - pop < BUF_DEPTH).
- imem_req_o=issue. imem_addr_o=fetch_pc_o=pc_q.
- On issue: pc_q <= {pred_pc_i[31:2],2'b00}. Capture inflight_q=1, inflight_pc=pc_q, inflight_taken=pred_taken_i, inflight_target=aligned pred_pc_i.
- Without issue and without flush, pc_q holds.
- Response cycle (inflight_q=1, no flush): push {imem_rdata_i, inflight_pc, inflight_taken, inflight_target} at the tail. Latency is issue edge to buffer-visible at the next edge, so back-to-back issue gives one instruction per cycle at steady state.
- Push and pop in the same cycle are both performed. count is unchanged and pointers wrap modulo BUF_DEPTH.
- Full: the issue rule guarantees no overflow; a response is never dropped for lack of space.
- Empty: valid_o=0. instr_o and the other head outputs hold their last values and are don't-care.
- flush_i=1 has priority over everything else:
  - valid_o forced to 0 combinationally, and a pop in that cycle is not counted.
  - Buffer cleared (count=0, pointers=0).
  - Any in-flight response arriving next cycle is discarded (inflight_q cleared).
  - pc_q <= {redirect_pc_i[31:2],2'b00}.
  - No issue that cycle; the first issue from the redirect PC occurs the following cycle.
- flush_i and stall_bp_i together: flush applies and pc_q takes the redirect.
- PC arithmetic is 32-bit and wraps at 2^32 with no error. Misaligned low bits of pred_pc_i/redirect_pc_i are zeroed.

Test Plan:
- Straight line:
  - Stimulus: release reset; memory holds 34080006,34090000,340a0001,340b0004 at 0x0..0xC; ready_i=1; predictor returns PC+4.
  - Required: imem_addr_o 0,4,8,C on consecutive cycles; valid_o rises after the 2nd post-reset edge; pc_o/instr_o stream 0/34080006, 4/34090000, 8/340a0001, C/340b0004 with no bubbles.
- Backpressure:
  - Stimulus: as above with ready_i=0 from reset for 5 cycles.
  - Required: buffer holds PCs 0 and 4; imem_req_o=0 and pc_q=0x8 while full; releasing ready_i yields 0,4,8 in order with no loss or duplicate.
- Predicted taken:
  - Stimulus: predictor returns pred_pc_i=0x10, pred_taken_i=1 when fetch_pc_o=0x1C (word 08000004).
  - Required: next imem_addr_o=0x10; the head for pc_o=0x1C shows pred_taken_o=1, pred_target_o=0x10.
- Flush with in-flight:
  - Stimulus: assert flush_i for 1 cycle with redirect_pc_i=0x20 while 0x14 is in flight and 0x10 is at the head.
  - Required: valid_o=0 that cycle; neither 0x10 nor 0x14 is ever delivered; next delivered pc_o=0x20 with instr 110b0002.
- Predictor stall:
  - Stimulus: stall_bp_i=1 for 3 cycles at pc_q=0x8.
  - Required: imem_req_o=0 and pc_q=0x8 for those cycles; buffered entries still drain; fetch resumes at 0x8.
- Reset mid-run:
  - Stimulus: drop rst_n asynchronously between edges with 2 entries buffered.
  - Required: valid_o=0 immediately; after release, fetch restarts at RESET_PC and the first pc_o=0x0.
